// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the unified memory port arbiter.
// Word width stands in for the CPU-wide WORD_SIZE constant.
package mem_arbiter_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and memory-side word handshake of the arbiter.
// master = arbiter view, slave = caches plus memory view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS
);
    logic                                 i_req;
    logic [WORD_SIZE-1:0]                 i_addr;
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0] i_rdata;
    logic                                 i_done;

    logic                                 d_req;
    logic                                 d_we;
    logic [WORD_SIZE-1:0]                 d_addr;
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0] d_wdata;
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0] d_rdata;
    logic                                 d_done;

    logic                                 mem_read;
    logic                                 mem_write;
    logic [WORD_SIZE-1:0]                 mem_addr;
    logic [WORD_SIZE-1:0]                 mem_wdata;
    logic [WORD_SIZE-1:0]                 mem_rdata;
    logic                                 mem_ready;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_done, d_rdata, d_done,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_done, d_rdata, d_done,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_burst_unit.sv
// Line burst datapath: word counter, word address, write-word register and
// one read line buffer per side.
module mem_burst_unit
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS,
    localparam int OFF       = $clog2(LINE_WORDS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 start_we,
    input  logic [WORD_SIZE-OFF-1:0]             start_base,
    input  logic                                 active,
    input  logic                                 side_d,
    input  logic                                 we,
    input  logic                                 mem_ready,
    input  logic [WORD_SIZE-1:0]                 mem_rdata,
    input  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0]                 mem_addr,
    output logic [WORD_SIZE-1:0]                 mem_wdata,
    output logic                                 last,
    output logic [LINE_WORDS-1:0][WORD_SIZE-1:0] i_line,
    output logic [LINE_WORDS-1:0][WORD_SIZE-1:0] d_line
);

    logic [OFF-1:0]           cnt;
    logic [OFF-1:0]           cnt_nxt;
    logic [WORD_SIZE-OFF-1:0] base_hi;

    assign cnt_nxt  = cnt + 1'b1;
    assign mem_addr = {base_hi, cnt};
    assign last     = (cnt == OFF'(LINE_WORDS - 1));

    // Write word is registered one word ahead so no input reaches mem_wdata
    // combinationally; d_wdata is stable for the whole burst.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            base_hi   <= '0;
            mem_wdata <= '0;
            i_line    <= '0;
            d_line    <= '0;
        end else if (start) begin
            cnt       <= '0;
            base_hi   <= start_base;
            mem_wdata <= start_we ? d_wdata[0] : '0;
        end else if (active && mem_ready) begin
            cnt <= cnt_nxt;
            if (we)
                mem_wdata <= d_wdata[cnt_nxt];
            else if (side_d)
                d_line[cnt] <= mem_rdata;
            else
                i_line[cnt] <= mem_rdata;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between I-cache refills and D-cache
// refills/writebacks, one whole line per grant. MEM_ARB_ROUND_ROBIN_EN selects
// alternating tie-break; otherwise D always wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS,
    localparam int OFF       = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);

    arb_state_e state;
    logic       we_q;
    logic       grant_d;
    logic       start;
    logic       active;
    logic       last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    side_e last_grant;
`endif

    always_comb begin
        grant_d = bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.i_req && bus.d_req)
            grant_d = (last_grant == SIDE_I);
`endif
    end

    assign start  = (state == ST_IDLE) && (bus.i_req || bus.d_req);
    assign active = (state == ST_GRANT_I) || (state == ST_GRANT_D);

    // Strobes are registered with the state so they line up with it; the
    // request inputs only steer the IDLE decision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            we_q          <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant    <= SIDE_I;
`endif
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= grant_d ? ST_GRANT_D : ST_GRANT_I;
                        we_q          <= grant_d && bus.d_we;
                        bus.mem_write <= grant_d && bus.d_we;
                        bus.mem_read  <= !(grant_d && bus.d_we);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant    <= grant_d ? SIDE_D : SIDE_I;
`endif
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    // Request level is ignored here: a started burst always completes.
                    if (bus.mem_ready && last) begin
                        state         <= ST_DONE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.i_done    <= (state == ST_GRANT_I);
                        bus.d_done    <= (state == ST_GRANT_D);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_burst_unit #(
        .WORD_SIZE  (WORD_SIZE),
        .LINE_WORDS (LINE_WORDS)
    ) u_burst (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_we   (grant_d && bus.d_we),
        .start_base (grant_d ? bus.d_addr[WORD_SIZE-1:OFF] : bus.i_addr[WORD_SIZE-1:OFF]),
        .active     (active),
        .side_d     (state == ST_GRANT_D),
        .we         (we_q),
        .mem_ready  (bus.mem_ready),
        .mem_rdata  (bus.mem_rdata),
        .d_wdata    (bus.d_wdata),
        .mem_addr   (bus.mem_addr),
        .mem_wdata  (bus.mem_wdata),
        .last       (last),
        .i_line     (bus.i_rdata),
        .d_line     (bus.d_rdata)
    );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single unified memory port between I-cache line refills and D-cache line refills/writebacks in the pipelined TSC CPU. Each grant is a full cache-line burst of LINE_WORDS word transfers, sequenced by a word counter against the memory's per-word ready handshake. While a cache waits for its grant, its miss remains visible to the hazard unit as a not-ready condition, stalling IF or MEM.

## Interface
- WORD_SIZE, 16, data/address word width
- LINE_WORDS, 4, words per cache line (power of two, ≥2)
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  I-cache refill request, level, held until i_done
- i_addr  in  WORD_SIZE  I-side miss address (word offset ignored)
- i_rdata  out  WORD_SIZE*LINE_WORDS  assembled line, word k at bits [16k+15:16k]
- i_done  out  1  one-cycle pulse; i_rdata valid this cycle
- d_req  in  1  D-cache request, level, held until d_done
- d_we  in  1  1 = line writeback, 0 = line refill; sampled at grant
- d_addr  in  WORD_SIZE  D-side line address
- d_wdata  in  WORD_SIZE*LINE_WORDS  writeback line, held stable until d_done
- d_rdata  out  WORD_SIZE*LINE_WORDS  assembled refill line
- d_done  out  1  one-cycle completion pulse
- mem_read  out  1  word read request
- mem_write  out  1  word write request
- mem_addr  out  WORD_SIZE  word address
- mem_wdata  out  WORD_SIZE  write data
- mem_rdata  in  WORD_SIZE  read data, valid when mem_ready
- mem_ready  in  1  current word accepted/returned

## Operation
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE: no request → stay. One request → grant it. Both → tie rule (Configuration). Base address and d_we latched at grant; word counter cleared.
- GRANT_x: mem_read (or mem_write if latched d_we) held high; mem_addr = {base[WORD_SIZE-1:log2(LINE_WORDS)], cnt}; mem_wdata = word cnt of d_wdata. On mem_ready: read word captured into line buffer slot cnt; cnt increments. On mem_ready with cnt == LINE_WORDS-1 → DONE.
- DONE: exactly one of i_done/d_done high for one cycle; mem_read/mem_write low; next state IDLE.
- Burst is atomic: dropping the request mid-burst does not abort; done still pulses.
- Reset (including mid-burst): state IDLE, cnt 0, last-grant = I, all outputs 0, rdata buses 0. A burst in progress is abandoned; memory side sees mem_read/mem_write low the following cycle.
- i_rdata/d_rdata hold their last line until the next burst to the same side begins overwriting.

## Timing
- Request sampled in IDLE at cycle 0 → mem_read/mem_write high from cycle 1 (registered grant).
- Zero-wait memory (mem_ready always 1): words at cycles 1..LINE_WORDS, done at LINE_WORDS+1, IDLE at LINE_WORDS+2; minimum request-to-done = LINE_WORDS+1 cycles.
- Each wait cycle (mem_ready=0) adds one cycle; address and data held stable.
- Back-to-back: one IDLE cycle between consecutive bursts; a request pending at DONE is arbitrated in the next IDLE cycle.
- No combinational path from inputs to outputs except line buffer → rdata.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE go to the side not granted most recently (last-grant register, reset = I, so D wins the first tie).
- Undefined: fixed priority, D always wins ties (MEM stall unblocks older instruction first); I may wait indefinitely under continuous D traffic. Last-grant register not built.

## Structure
- Shared package: state encoding localparams, LINE_WORDS default, OFFSET_BITS = log2(LINE_WORDS); WORD_SIZE from constants.v.
- Sub-module mem_burst_unit: word counter, address composition, write-word mux, read line buffer; mem_arbiter holds arbitration FSM and done generation.

## Test plan
- i_req only, i_addr=0x0123, mem_ready=1 → mem_addr 0x0120..0x0123 at cycles 1..4, i_done at cycle 5 with line assembled.
- d_req, d_we=1, d_addr=0x0040, d_wdata=0x4444_3333_2222_1111 → mem_write, mem_wdata 0x1111,0x2222,0x3333,0x4444 to 0x40..0x43, d_done at cycle 5, no mem_read.
- i_req and d_req together at cycle 0 → D granted first, I granted in the IDLE cycle after d_done; with MEM_ARB_ROUND_ROBIN_EN a second tie then goes to I.
- mem_ready low for 3 cycles on word 2 → mem_addr held at word 2; done delayed 3 cycles to cycle 8.
- reset_n low at cycle 3 of an I burst → next cycle IDLE, mem_read 0, i_done never pulses; fresh i_req restarts at word 0.
